rf_dump_reader: RTL and testbench
=================================

Name: rf_dump_reader

Overview:
- Sequential reader for the CPU register file: on request, walks register indices FIRST_REG..LAST_REG through an RF read port and streams each (index, value) pair out on a valid/ready interface.
- Sits beside the RF on a spare read port. Serves the debug/trace path and the testbench scoreboard for end-of-program register checks.
- Does not write the RF.

Parameters:
- DATA_W, 32, RF data width.
- ADDR_W, 5, RF index width.
- FIRST_REG, 0, first index dumped.
- LAST_REG, 31, last index dumped; FIRST_REG <= LAST_REG <= 2**ADDR_W-1 is required.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  dump request; sampled only in IDLE.
- i_abort  in  1  synchronous cancel of a dump in progress.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse after the last beat is accepted.
- o_rf_addr  out  ADDR_W  RF read index; equals the internal idx register.
- i_rf_data  in  DATA_W  RF read data; combinational from o_rf_addr.
- o_valid  out  1  stream beat valid.
- i_ready  in  1  stream sink ready.
- o_index  out  ADDR_W  register index of the current beat.
- o_data  out  DATA_W  register value of the current beat.

Behaviour:
- Reset (async, active-low): state=IDLE, idx=FIRST_REG. o_busy, o_done, o_valid = 0. o_index and o_data = 0. o_rf_addr=FIRST_REG.
- All outputs are registered or are direct state decodes. No combinational path from i_ready to o_valid.
- FSM states: IDLE, READ, SEND, DONE.
  - IDLE: if i_start, then idx<=FIRST_REG and go to READ. Otherwise stay.
  - READ: o_data<=i_rf_data, o_index<=idx, o_valid<=1, go to SEND. This is a one-cycle sample.
  - SEND: hold o_valid, o_data and o_index stable while i_ready=0.
    - On i_ready=1 with idx==LAST_REG: o_valid<=0, go to DONE.
    - On i_ready=1 otherwise: o_valid<=0, idx<=idx+1, go to READ.
  - DONE: o_done=1 for exactly this cycle, then go to IDLE. idx<=FIRST_REG.
- Latency and throughput:
  - i_start accepted at edge N gives READ in cycle N+1 and the first o_valid in cycle N+2.
  - With i_ready held high, one beat every 2 cycles.
  - A full 32-register dump with no backpressure takes 64 cycles from start to last accept. o_done follows in the next cycle.
- i_abort, in READ or SEND: go to IDLE, o_valid<=0, idx<=FIRST_REG, no o_done.
  - i_abort takes priority over i_ready in the same cycle. The beat is not accepted.
  - i_abort in IDLE or DONE is ignored. DONE still pulses.
- i_start while busy is ignored; it is not queued. i_start in DONE is ignored.
- The block forwards i_rf_data unmodified, including index 0; the RF itself forces index-0 reads to 0.
- Coherency: each register is sampled in its own READ cycle.
  - An RF write at or before the edge that enters READ for that index is visible in the sample. Later writes are not.
  - A dump is not an atomic snapshot.
- idx never increments past LAST_REG. No wrap-around when LAST_REG = 2**ADDR_W-1; the idx==LAST_REG check precedes the increment.
- Reset asserted mid-dump: immediate return to reset values. The partial stream is abandoned.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults, matching the RF, and the FSM state encoding (2-bit enum: IDLE=0, READ=1, SEND=2, DONE=3).
- Single module, no sub-module needed. The index counter and the output holding register are inline.

Test Plan:
- Reset: assert i_rst_n=0 mid-cycle -> all outputs 0 and o_rf_addr=0 immediately, no clock needed.
- Full dump, i_ready=1:
  - Stimulus: preload RF[k]=32'hA000_0000+k, with RF[0] reading 0; pulse i_start at edge 0.
  - Required: 32 beats, o_index 0..31, o_data matches the preload, o_valid high in cycles 2,4,...,64.
  - Required: o_done pulses in cycle 65 only.
- Backpressure: i_ready=0 for 5 cycles on beat index 3 -> o_valid, o_index=3 and o_data stay stable all 5 cycles; index 4 follows only after the accept.
- Start while busy and abort:
  - Stimulus: i_start pulsed during SEND of index 7; then i_abort=1 with i_ready=1 in SEND of index 9.
  - Required: the extra start has no effect; no beat 9 accepted, o_valid=0 next cycle, o_busy=0, no o_done.
- Write coherency: RF write of 32'hDEAD_BEEF to reg 12 issued on the edge entering READ for idx 12 -> beat 12 carries DEAD_BEEF. The same write one cycle later -> old value.
- Single-register parameterisation: FIRST_REG=LAST_REG=5 -> exactly one beat, o_index=5, then o_done. o_rf_addr never leaves 5.

Source files
------------

// File: rtl/rf_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_reader_pkg
//  Purpose  : Shared definitions for the register-file dump reader. Holds the
//             default RF geometry (matching the CPU register file) and the
//             reader FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rf_dump_reader_pkg;

  // Default RF geometry; must match the register file the reader sits beside.
  localparam int c_rf_data_w = 32;
  localparam int c_rf_addr_w = 5;

  // Reader FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // True in the states where a dump is actually walking the RF, i.e. where
  // an abort has an effect.
  function automatic logic is_walking(input state_t s);
    return (s == ST_READ) || (s == ST_SEND);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_dump_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_reader_if
//  Purpose  : Bundles the RF read port and the (index, value) stream of the
//             dump reader. Signal names are from the reader's point of view.
//  Ports    : o_rf_addr  - RF read index         (reader -> RF)
//             i_rf_data  - RF read data          (RF -> reader, comb.)
//             o_valid    - stream beat valid     (reader -> sink)
//             i_ready    - stream sink ready     (sink -> reader)
//             o_index    - register index of beat
//             o_data     - register value of beat
//  Modports : master - the reader; slave - RF plus stream sink
//  Revision : 1.0 - initial release
// ============================================================================
interface rf_dump_reader_if
  import rf_dump_reader_pkg::*;
#(
  parameter int DATA_W = c_rf_data_w,
  parameter int ADDR_W = c_rf_addr_w
);

  logic [ADDR_W-1:0] o_rf_addr;
  logic [DATA_W-1:0] i_rf_data;
  logic              o_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] o_index;
  logic [DATA_W-1:0] o_data;

  modport master (
    output o_rf_addr,
    input  i_rf_data,
    output o_valid,
    input  i_ready,
    output o_index,
    output o_data
  );

  modport slave (
    input  o_rf_addr,
    output i_rf_data,
    input  o_valid,
    output i_ready,
    input  o_index,
    input  o_data
  );

endinterface
`default_nettype wire

// File: rtl/rf_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : rf_dump_reader
//  Purpose  : On request, walks RF indices FIRST_REG..LAST_REG through a spare
//             RF read port and streams each (index, value) pair out on a
//             valid/ready interface. One beat every two cycles without
//             backpressure. Never writes the RF.
//  Ports    : i_clk    - clock, rising edge
//             i_rst_n  - asynchronous active-low reset
//             i_start  - dump request, sampled only in IDLE
//             i_abort  - synchronous cancel while reading/sending
//             o_busy   - high whenever not IDLE
//             o_done   - one-cycle pulse after the last beat is accepted
//             bus      - RF read port + output stream (master modport)
//  Params   : DATA_W, ADDR_W, FIRST_REG, LAST_REG
//             (FIRST_REG <= LAST_REG <= 2**ADDR_W-1)
//  Revision : 1.0 - initial release
// ============================================================================
module rf_dump_reader
  import rf_dump_reader_pkg::*;
#(
  parameter int DATA_W    = c_rf_data_w,
  parameter int ADDR_W    = c_rf_addr_w,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  input  wire logic         i_start,
  input  wire logic         i_abort,
  output logic              o_busy,
  output logic              o_done,
  rf_dump_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0] c_first = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(LAST_REG);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              w_capture;
  logic [ADDR_W-1:0] r_index;
  logic [DATA_W-1:0] r_data;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_capture   = 1'b0;

    // Abort wins over a same-cycle i_ready, so the pending beat is dropped
    // rather than accepted.
    if (i_abort && is_walking(r_state)) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = 1'b0;
      w_idx_nxt   = c_first;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_idx_nxt   = c_first;
            w_state_nxt = ST_READ;
          end
        end
        ST_READ: begin
          // Single-cycle sample: the RF value seen here is whatever the RF
          // holds after the edge that entered READ.
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_SEND;
        end
        ST_SEND: begin
          if (bus.i_ready) begin
            w_valid_nxt = 1'b0;
            // Compare before incrementing so idx never wraps when LAST_REG
            // is the top index.
            if (r_idx == c_last) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_idx_nxt   = r_idx + ADDR_W'(1);
              w_state_nxt = ST_READ;
            end
          end
        end
        ST_DONE: begin
          w_idx_nxt   = c_first;
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Index counter, valid flag and beat holding register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= c_first;
      r_valid <= 1'b0;
      r_index <= '0;
      r_data  <= '0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      if (w_capture) begin
        r_index <= r_idx;
        r_data  <= bus.i_rf_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: registers or direct state decodes only
  // --------------------------------------------------------------------------
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_DONE);
  assign bus.o_rf_addr = r_idx;
  assign bus.o_valid   = r_valid;
  assign bus.o_index   = r_index;
  assign bus.o_data    = r_data;

endmodule
`default_nettype wire

// File: tb/tb_rf_dump_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_dump_reader
//  Purpose  : Directed self-checking bench for rf_dump_reader. Instance A
//             dumps the full 32-entry RF; instance B dumps only register 5.
//             A small RF model with a synchronous write port feeds both.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_dump_reader;
  import rf_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, start_b, abort_b;
  logic        busy, done, busy_b, done_b;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] rf [32];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rf_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  rf_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  rf_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(0), .LAST_REG(31)) dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_abort (abort),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus_a.master)
  );

  rf_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(5), .LAST_REG(5)) dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start_b),
    .i_abort (abort_b),
    .o_busy  (busy_b),
    .o_done  (done_b),
    .bus     (bus_b.master)
  );

  // RF model: synchronous write, combinational read, index 0 reads as zero.
  always @(posedge clk) if (we) rf[wa] <= wd;
  assign bus_a.i_rf_data = (bus_a.o_rf_addr == 5'd0) ? 32'd0 : rf[bus_a.o_rf_addr];
  assign bus_b.i_rf_data = (bus_b.o_rf_addr == 5'd0) ? 32'd0 : rf[bus_b.o_rf_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rf(input int k);
    if (k == 0) return 32'd0;
    return 32'hA000_0000 + 32'(k);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_beat(input int k, input logic [31:0] d);
    int n = 0;
    while (!bus_a.o_valid && n < 8) begin
      step();
      n++;
    end
    chk($sformatf("beat%0d_valid", k), bus_a.o_valid, 1);
    chk($sformatf("beat%0d_index", k), bus_a.o_index, k);
    chk($sformatf("beat%0d_data", k), bus_a.o_data, d);
  endtask

  // Dumps up to beat 12 and aborts there. late=0: write of reg 12 lands on the
  // edge entering READ for 12 (visible). late=1: one edge later (not visible).
  task automatic coherency_run(input bit late);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      expect_beat(k, (k == 12 && !late) ? 32'hDEAD_BEEF : exp_rf(k));
      if (k == 11 && !late) begin
        we = 1'b1; wa = 5'd12; wd = 32'hDEAD_BEEF;
      end
      if (k == 12) abort = 1'b1;
      step();
      we = 1'b0;
      abort = 1'b0;
      if (k == 11 && late) begin
        we = 1'b1; wa = 5'd12; wd = 32'hDEAD_BEEF;
        step();
        we = 1'b0;
      end
    end
    chk("coh_idle_after_abort", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    bus_a.i_ready = 1'b0;
    bus_b.i_ready = 1'b0;
    we = 1'b0; wa = '0; wd = '0;

    // ---- reset values, asserted mid-cycle with no clock edge in between
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus_a.o_valid, 0);
    chk("rst_index", bus_a.o_index, 0);
    chk("rst_data", bus_a.o_data, 0);
    chk("rst_rf_addr", bus_a.o_rf_addr, 0);
    chk("rst_rf_addr_b", bus_b.o_rf_addr, 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- preload RF[k] = A000_0000 + k
    for (int k = 0; k < 32; k++) begin
      we = 1'b1; wa = 5'(k); wd = 32'hA000_0000 + 32'(k);
      step();
    end
    we = 1'b0;

    // ---- full dump, no backpressure: valid in cycles 2..64 (even), done in 65
    bus_a.i_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 66; c++) begin
      chk($sformatf("full_c%0d_valid", c), bus_a.o_valid, (c % 2 == 0) && (c <= 64));
      chk($sformatf("full_c%0d_done", c), done, c == 65);
      chk($sformatf("full_c%0d_busy", c), busy, c <= 65);
      if ((c % 2 == 0) && (c <= 64)) begin
        chk($sformatf("full_c%0d_index", c), bus_a.o_index, c / 2 - 1);
        chk($sformatf("full_c%0d_data", c), bus_a.o_data, exp_rf(c / 2 - 1));
      end
      step();
    end

    // ---- backpressure on beat 3, extra start in beat 7, abort in beat 9
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      expect_beat(k, exp_rf(k));
      if (k == 3) begin
        bus_a.i_ready = 1'b0;
        repeat (4) begin
          step();
          chk("bp_valid_hold", bus_a.o_valid, 1);
          chk("bp_index_hold", bus_a.o_index, 3);
          chk("bp_data_hold", bus_a.o_data, exp_rf(3));
        end
        bus_a.i_ready = 1'b1;
      end
      if (k == 7) start = 1'b1;
      if (k == 9) abort = 1'b1;
      step();
      start = 1'b0;
      if (k == 9) begin
        abort = 1'b0;
        chk("abort_valid", bus_a.o_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rf_addr", bus_a.o_rf_addr, 0);
        repeat (3) begin
          step();
          chk("abort_no_done", done, 0);
          chk("abort_stays_idle", busy, 0);
        end
      end else begin
        chk($sformatf("after_accept%0d_valid", k), bus_a.o_valid, 0);
      end
    end

    // ---- write coherency: on-time write visible, late write not
    coherency_run(1'b0);
    we = 1'b1; wa = 5'd12; wd = 32'hA000_000C;
    step();
    we = 1'b0;
    coherency_run(1'b1);

    // ---- reset asserted mid-dump while beat 4 is on the bus
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_beat(k, exp_rf(k));
      step();
    end
    expect_beat(4, exp_rf(4));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bus_a.o_valid, 0);
    chk("mid_rst_index", bus_a.o_index, 0);
    chk("mid_rst_data", bus_a.o_data, 0);
    chk("mid_rst_rf_addr", bus_a.o_rf_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);

    // ---- single-register instance: FIRST_REG = LAST_REG = 5
    bus_b.i_ready = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("single_c1_valid", bus_b.o_valid, 0);
    chk("single_c1_busy", busy_b, 1);
    chk("single_c1_addr", bus_b.o_rf_addr, 5);
    step();
    chk("single_c2_valid", bus_b.o_valid, 1);
    chk("single_c2_index", bus_b.o_index, 5);
    chk("single_c2_data", bus_b.o_data, 32'hA000_0005);
    chk("single_c2_addr", bus_b.o_rf_addr, 5);
    step();
    chk("single_c3_done", done_b, 1);
    chk("single_c3_valid", bus_b.o_valid, 0);
    chk("single_c3_addr", bus_b.o_rf_addr, 5);
    step();
    chk("single_c4_done", done_b, 0);
    chk("single_c4_busy", busy_b, 0);
    chk("single_c4_addr", bus_b.o_rf_addr, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
